// File: rtl/wb_stage_pipe_if.sv
// MEM/WB bus: MEM-stage results and stage controls in, register-file write port out.
// wb_retire_cnt is only live when WB_RETIRE_CNT_EN is defined.
interface wb_stage_pipe_if #(
   parameter int DATA_W       = 32,
   parameter int REG_ADDR_W   = 5,
   parameter int RETIRE_CNT_W = 32
);
   logic                    mem_valid;
   logic [1:0]              mem_control_wb;
   logic [DATA_W-1:0]       mem_read_data;
   logic [DATA_W-1:0]       mem_alu_result;
   logic [1:0]              mem_load_size;
   logic                    mem_load_unsigned;
   logic [REG_ADDR_W-1:0]   mem_rd;
   logic                    wb_stall;
   logic                    wb_flush;
   logic                    wb_valid;
   logic                    wb_reg_write;
   logic [REG_ADDR_W-1:0]   wb_rd;
   logic [DATA_W-1:0]       wb_data;
   logic [RETIRE_CNT_W-1:0] wb_retire_cnt;

   modport master (
      output mem_valid, mem_control_wb, mem_read_data,
      output mem_alu_result, mem_load_size,
      output mem_load_unsigned, mem_rd,
      output wb_stall, wb_flush,
      input  wb_valid, wb_reg_write, wb_rd,
      input  wb_data, wb_retire_cnt
   );

   modport slave (
      input  mem_valid, mem_control_wb, mem_read_data,
      input  mem_alu_result, mem_load_size,
      input  mem_load_unsigned, mem_rd,
      input  wb_stall, wb_flush,
      output wb_valid, wb_reg_write, wb_rd,
      output wb_data, wb_retire_cnt
   );
endinterface

// File: rtl/wb_stage_pipe.sv
// MEM/WB pipeline register with sub-word load alignment/extension.
// Optional retire counter built only when WB_RETIRE_CNT_EN is defined.
module wb_stage_pipe #(
   parameter int DATA_W       = 32,
   parameter int REG_ADDR_W   = 5,
   parameter int RETIRE_CNT_W = 32
) (
   input logic          clk,
   input logic          rst_n,
   wb_stage_pipe_if.slave bus
);
   localparam int LANE_W = $clog2(DATA_W/8);
   localparam int SH_W   = LANE_W + 3;
   localparam int MSB_W  = $clog2(DATA_W);

   logic [LANE_W-1:0]     w_off;
   logic [LANE_W-1:0]     w_off_h;
   logic [LANE_W-1:0]     w_off_w;
   logic [SH_W-1:0]       w_sh;
   logic [MSB_W-1:0]      w_msb;
   logic [DATA_W-1:0]     w_mask;
   logic [DATA_W-1:0]     w_raw;
   logic [DATA_W-1:0]     w_load;
   logic [DATA_W-1:0]     w_sel;
   logic                  w_neg;
   logic                  w_rw;
   logic                  w_cap;

   logic                  r_valid;
   logic                  r_rw;
   logic [REG_ADDR_W-1:0] r_rd;
   logic [DATA_W-1:0]     r_data;

   assign w_off   = bus.mem_alu_result[LANE_W-1:0];
   assign w_off_h = w_off & ~LANE_W'(1);
   assign w_off_w = w_off & ~LANE_W'(3);

   // Size 11 and full-width word loads take the default: no shift, no mask.
   always_comb begin
      w_sh   = '0;
      w_mask = '1;
      w_msb  = MSB_W'(DATA_W-1);
      unique case (1'b1)
         (bus.mem_load_size == 2'b00): begin
            w_sh   = {w_off, 3'b000};
            w_mask = DATA_W'(8'hFF);
            w_msb  = MSB_W'(7);
         end
         (bus.mem_load_size == 2'b01): begin
            w_sh   = {w_off_h, 3'b000};
            w_mask = DATA_W'(16'hFFFF);
            w_msb  = MSB_W'(15);
         end
         (bus.mem_load_size == 2'b10): begin
            w_sh   = {w_off_w, 3'b000};
            w_mask = DATA_W'(32'hFFFF_FFFF);
            w_msb  = MSB_W'(31);
         end
         default: begin
         end
      endcase
   end

   assign w_raw  = (bus.mem_read_data >> w_sh) & w_mask;
   assign w_neg  = ~bus.mem_load_unsigned & w_raw[w_msb];
   assign w_load = w_neg ? (w_raw | ~w_mask) : w_raw;
   assign w_sel  = bus.mem_control_wb[1] ? w_load
                                         : bus.mem_alu_result;
   assign w_rw   = bus.mem_valid & bus.mem_control_wb[0]
                 & (bus.mem_rd != '0);
   assign w_cap  = ~bus.wb_flush & ~bus.wb_stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_rw    <= 1'b0;
         r_rd    <= '0;
         r_data  <= '0;
      end else if (bus.wb_flush) begin
         r_valid <= 1'b0;
         r_rw    <= 1'b0;
         r_rd    <= '0;
         r_data  <= '0;
      end else if (w_cap) begin
         r_valid <= bus.mem_valid;
         r_rw    <= w_rw;
         r_rd    <= bus.mem_rd;
         r_data  <= w_sel;
      end
   end

   assign bus.wb_valid     = r_valid;
   assign bus.wb_reg_write = r_rw;
   assign bus.wb_rd        = r_rd;
   assign bus.wb_data      = r_data;

`ifdef WB_RETIRE_CNT_EN
   logic [RETIRE_CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cnt <= '0;
      else if (w_cap & bus.mem_valid)
         r_cnt <= r_cnt + RETIRE_CNT_W'(1);
   end

   assign bus.wb_retire_cnt = r_cnt;
`else
   assign bus.wb_retire_cnt = '0;
`endif
endmodule
